fwnoc_mesh: RTL and testbench
=============================

Name: fwnoc_mesh

Overview:
- X_SIZE x Y_SIZE 2D mesh network-on-chip of wormhole routers, 32-bit flits.
- External access only through perimeter edge ports: N_PORTS = 2*(X_SIZE+Y_SIZE).
  - Each edge port has an ingress channel (i_*) and an egress channel (e_*).
  - Both channels use ready/valid handshakes.
- Top-level fabric between endpoint agents; packets enter on any edge port and leave on the edge port named in the header.

Parameters:
- FIFO_DEPTH, 4: flit depth of every router input FIFO; must be >= 2.
- X_SIZE, 2: mesh columns; must be >= 1.
- Y_SIZE, 2: mesh rows; must be >= 1.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- i_dat  in  32*N_PORTS  ingress flits; port p uses bits [32p+31:32p].
- i_valid  in  N_PORTS  ingress flit valid per port.
- i_ready  out  N_PORTS  ingress ready per port.
- e_dat  out  32*N_PORTS  egress flits, same packing as i_dat.
- e_valid  out  N_PORTS  egress valid per port.
- e_ready  in  N_PORTS  egress ready per port.

Behaviour:
- Transfer rule: a flit transfers when valid && ready at a rising edge.
- Valid stability: once asserted, valid/dat must stay stable until the transfer.
- Edge port numbering, router (x,y), y=0 is the north row:
  - North: p = x, for 0..X_SIZE-1.
  - South: p = X_SIZE + x.
  - West: p = 2*X_SIZE + y.
  - East: p = 2*X_SIZE + Y_SIZE + y.
- Packet format: header flit followed by LEN payload flits.
  - Header [7:0] = destination port; [15:8] = LEN (0..255); [31:16] = user field.
  - The header is carried unmodified.
- Routing (dimension-order XY):
  - Destination router is derived from the destination port.
  - Move in X to the destination column, then in Y to the destination row.
  - At the destination router, exit on the edge direction of the destination port.
- Wormhole switching:
  - The header allocates a router output.
  - The output stays locked to that input until LEN payload flits have passed.
  - Payload flits are never reordered or interleaved with other packets on a locked output.
- Arbitration: per-output round-robin among inputs with a pending header.
  - The pointer advances past the winner when its packet tail leaves.
- Flow control:
  - i_ready = ingress FIFO not full.
  - Inter-router links use the same ready/valid rule.
  - No flit is ever dropped, except in the invalid-destination case below.
- Latency:
  - Each router input FIFO is registered; the head drives the output combinationally.
  - An uncontended flit accepted at cycle t appears on e_valid at cycle t+R.
  - R = number of routers traversed (hops + 1).
  - Throughput is 1 flit/cycle/link when uncontended.
- Invalid destination (>= N_PORTS): the ingress router accepts header and LEN payload flits and discards them. Nothing is emitted.
- Simultaneous events:
  - Push and pop on a full FIFO in the same cycle is allowed; occupancy is unchanged.
  - i_ready reflects the registered full state (no combinational ready-through).
- Reset (reset==0 at a clock edge):
  - FIFOs emptied, locks cleared, round-robin pointers set to 0.
  - e_valid=0 and i_ready=0 while reset is asserted.
  - Reset mid-packet discards all in-flight flits; partial packets are not completed.
- Back-pressure: with e_ready low, the path fills, then i_ready drops on the ingress port. Other traffic not needing the blocked outputs continues.

Decomposition:
- Package fwnoc_mesh_pkg:
  - Direction enum (NORTH, SOUTH, EAST, WEST) and header field positions/widths.
  - Functions: port-to-(x,y,dir), route-compute (current x,y,dest -> output dir), N_PORTS calc.
- One sub-module, fwnoc_mesh_router:
  - 4 directional input FIFOs (FIFO_DEPTH), route compute, per-output lock + round-robin arbiter.
  - Discard logic for invalid destinations.
- Top level instantiates the X_SIZE*Y_SIZE router array.
  - Neighbour links are wired between routers.
  - Unused perimeter directions connect to the i_/e_ buses.

Test Plan (2x2, N_PORTS=8: N 0,1; S 2,3; W 4,5; E 6,7):
- Reset held low 20 cycles -> e_valid=0, i_ready=0; after release, i_ready=8'hFF within 1 cycle.
- Port 4 sends header 32'h0000_0206 (dest 6, LEN 2) + payload 32'hA1, 32'hA2 with e_ready=1 -> port 6 emits the 3 flits in order, each 2 cycles after acceptance.
- Port 0 sends dest 3, LEN 0 -> single header flit exits port 3 after 3 cycles: routers (0,0)->(1,0)->(1,1).
- Ports 4 and 0 both send LEN 3 packets to port 7 simultaneously -> two contiguous, non-interleaved packets on port 7; the later-arbitrated one is held, with ingress back-pressured once its FIFOs fill.
- e_ready[6]=0, port 4 streams to dest 6 -> i_ready[4] drops after 2*FIFO_DEPTH=8 accepted flits. Releasing e_ready delivers all flits with no loss or duplication.
- Port 5 sends dest 8'h20, LEN 1 -> 2 flits accepted; no e_valid on any port. A following valid packet is delivered normally.

Source files
------------

// File: rtl/fwnoc_mesh_pkg.sv
// fwnoc_mesh_pkg: shared types and helpers for the mesh NoC.
//   dir_e       router side / edge direction (NORTH=0, SOUTH=1, EAST=2, WEST=3;
//               opposite direction is dir ^ 1)
//   header      [7:0] destination port, [15:8] payload length, [31:16] user
//   n_ports_calc, port_loc (port -> router x,y + exit side), route_dir (XY routing)
package fwnoc_mesh_pkg;
  localparam int FLIT_W   = 32;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 8;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 8;

  typedef enum logic [1:0] {NORTH = 2'd0, SOUTH = 2'd1, EAST = 2'd2, WEST = 2'd3} dir_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    dir_e       dir;
  } loc_t;

  function automatic int n_ports_calc(input int xs, input int ys);
    return 2 * (xs + ys);
  endfunction

  // y=0 is the north row; ports run N, S, W, E.
  function automatic loc_t port_loc(input int p, input int xs, input int ys);
    loc_t l;
    l.x = '0; l.y = '0; l.dir = NORTH;
    if (p < xs) begin
      l.x = 8'(p);
    end else if (p < 2*xs) begin
      l.x = 8'(p - xs); l.y = 8'(ys - 1); l.dir = SOUTH;
    end else if (p < 2*xs + ys) begin
      l.y = 8'(p - 2*xs); l.dir = WEST;
    end else begin
      l.x = 8'(xs - 1); l.y = 8'(p - 2*xs - ys); l.dir = EAST;
    end
    return l;
  endfunction

  // Dimension-order: resolve X first, then Y, then leave on the port's side.
  function automatic dir_e route_dir(input logic [7:0] cx, input logic [7:0] cy,
                                     input logic [7:0] dest, input int xs, input int ys);
    loc_t d;
    d = port_loc(int'(dest), xs, ys);
    if (d.x > cx) return EAST;
    if (d.x < cx) return WEST;
    if (d.y > cy) return SOUTH;
    if (d.y < cy) return NORTH;
    return d.dir;
  endfunction
endpackage

// File: rtl/fwnoc_mesh_if.sv
// fwnoc_mesh_if: perimeter edge-port bundle. Port p uses dat bits [32p+31:32p].
//   i_*  ingress (agent -> mesh), e_*  egress (mesh -> agent), ready/valid.
//   master = endpoint agents, slave = the mesh.
interface fwnoc_mesh_if #(parameter int N_PORTS = 8);
  import fwnoc_mesh_pkg::*;
  logic [FLIT_W*N_PORTS-1:0] i_dat;
  logic [N_PORTS-1:0]        i_valid;
  logic [N_PORTS-1:0]        i_ready;
  logic [FLIT_W*N_PORTS-1:0] e_dat;
  logic [N_PORTS-1:0]        e_valid;
  logic [N_PORTS-1:0]        e_ready;

  modport master (output i_dat, i_valid, e_ready, input i_ready, e_dat, e_valid);
  modport slave  (input i_dat, i_valid, e_ready, output i_ready, e_dat, e_valid);
endinterface

// File: rtl/fwnoc_mesh_router.sv
// fwnoc_mesh_router: one wormhole router at (RX,RY).
//   in_*  four directional inputs (index = dir_e), each into a FIFO_DEPTH FIFO
//   out_* four directional outputs, driven combinationally from FIFO heads
// A header locks its output until LEN payload flits pass; per-output round-robin
// among pending headers. Headers with a destination >= N_PORTS are swallowed
// together with their payload.
module fwnoc_mesh_router
  import fwnoc_mesh_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_SIZE     = 2,
  parameter int Y_SIZE     = 2,
  parameter int RX         = 0,
  parameter int RY         = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0][FLIT_W-1:0] in_dat,
  input  logic [3:0]             in_valid,
  output logic [3:0]             in_ready,
  output logic [3:0][FLIT_W-1:0] out_dat,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready
);
  localparam int NP = n_ports_calc(X_SIZE, Y_SIZE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                   up;       // low during and one cycle after reset: holds i_ready low
  logic [3:0][FLIT_W-1:0] head;
  logic [3:0]             hv, pop, busy, drop, bad, tail_i;
  dir_e                   want [4];
  logic [3:0]             oxfer;
  logic [1:0]             osel [4];

  always_ff @(posedge clock) up <= reset;

  for (genvar i = 0; i < 4; i++) begin : g_in
    logic [FIFO_DEPTH-1:0][FLIT_W-1:0] mem;
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    fcnt;
    logic [LEN_W-1:0] rem, hlen;
    logic             busy_q, drop_q, push;

    assign in_ready[i] = up && (fcnt != CW'(FIFO_DEPTH));
    assign push        = in_valid[i] && in_ready[i];
    assign hv[i]       = (fcnt != '0);
    assign head[i]     = mem[rp];
    assign hlen        = head[i][LEN_LSB +: LEN_W];
    assign bad[i]      = head[i][DEST_LSB +: DEST_W] >= 8'(NP);
    assign want[i]     = route_dir(8'(RX), 8'(RY), head[i][DEST_LSB +: DEST_W], X_SIZE, Y_SIZE);
    assign busy[i]     = busy_q;
    assign drop[i]     = drop_q;
    // head is the last flit of its packet (payload count hits 1, or LEN=0 header)
    assign tail_i[i]   = busy_q ? (rem == LEN_W'(1)) : (hlen == '0);

    always_ff @(posedge clock) if (push) mem[wp] <= in_dat[i];

    always_ff @(posedge clock) begin
      if (!reset) begin
        wp <= '0; rp <= '0; fcnt <= '0;
        busy_q <= 1'b0; drop_q <= 1'b0; rem <= '0;
      end else begin
        if (push) wp <= (wp == PW'(FIFO_DEPTH-1)) ? '0 : wp + 1'b1;
        if (pop[i]) rp <= (rp == PW'(FIFO_DEPTH-1)) ? '0 : rp + 1'b1;
        fcnt <= fcnt + CW'(push) - CW'(pop[i]);
        if (pop[i]) begin
          if (!busy_q) begin
            busy_q <= (hlen != '0);
            drop_q <= bad[i];
            rem    <= hlen;
          end else begin
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin busy_q <= 1'b0; drop_q <= 1'b0; end
          end
        end
      end
    end
  end

  for (genvar o = 0; o < 4; o++) begin : g_out
    logic       locked, any, xfer;
    logic [1:0] owner, rr, win, sel, idx;
    logic [3:0] rq;

    always_comb begin
      rq = '0;
      for (int i = 0; i < 4; i++)
        rq[i] = hv[i] && !busy[i] && !bad[i] && (want[i] == dir_e'(o));
    end

    always_comb begin
      win = rr; any = 1'b0; idx = rr;
      for (int k = 0; k < 4; k++) begin
        idx = rr + 2'(k);
        if (!any && rq[idx]) begin win = idx; any = 1'b1; end
      end
    end

    // The arbiter winner is locked in even before its header moves so the
    // presented flit cannot change while the downstream link stalls.
    assign sel          = locked ? owner : win;
    assign out_valid[o] = locked ? hv[owner] : any;
    assign out_dat[o]   = head[sel];
    assign xfer         = out_valid[o] && out_ready[o];
    assign oxfer[o]     = xfer;
    assign osel[o]      = sel;

    always_ff @(posedge clock) begin
      if (!reset) begin
        locked <= 1'b0; owner <= '0; rr <= '0;
      end else if (xfer && tail_i[sel]) begin
        locked <= 1'b0;
        rr     <= sel + 2'd1;
      end else if (!locked && any) begin
        locked <= 1'b1;
        owner  <= win;
      end
    end
  end

  // Pop on a forwarded flit, or self-pop while discarding a bad packet.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 4; i++) begin
      pop[i] = hv[i] && (busy[i] ? drop[i] : bad[i]);
      for (int o = 0; o < 4; o++)
        if (oxfer[o] && osel[o] == 2'(i)) pop[i] = 1'b1;
    end
  end
endmodule

// File: rtl/fwnoc_mesh.sv
// fwnoc_mesh: X_SIZE x Y_SIZE wormhole mesh, 32-bit flits, XY routing.
//   clock  rising-edge clock
//   reset  synchronous active-low reset
//   bus    perimeter edge ports (N: x, S: X+x, W: 2X+y, E: 2X+Y+y)
// Routers sitting on the perimeter expose their outward side on bus; every
// other side is a point-to-point link to the neighbouring router.
module fwnoc_mesh
  import fwnoc_mesh_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_SIZE     = 2,
  parameter int Y_SIZE     = 2
) (
  input  logic         clock,
  input  logic         reset,
  fwnoc_mesh_if.slave  bus
);
  localparam int NR = X_SIZE * Y_SIZE;

  logic [3:0][FLIT_W-1:0] rid [NR];
  logic [3:0][FLIT_W-1:0] rod [NR];
  logic [3:0]             riv [NR];
  logic [3:0]             rir [NR];
  logic [3:0]             rov [NR];
  logic [3:0]             ror [NR];

  for (genvar y = 0; y < Y_SIZE; y++) begin : g_y
    for (genvar x = 0; x < X_SIZE; x++) begin : g_x
      localparam int R = y * X_SIZE + x;

      fwnoc_mesh_router #(
        .FIFO_DEPTH(FIFO_DEPTH), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .RX(x), .RY(y)
      ) u_rtr (
        .clock    (clock),
        .reset    (reset),
        .in_dat   (rid[R]),
        .in_valid (riv[R]),
        .in_ready (rir[R]),
        .out_dat  (rod[R]),
        .out_valid(rov[R]),
        .out_ready(ror[R])
      );

      for (genvar d = 0; d < 4; d++) begin : g_d
        localparam int  NX   = (d == int'(EAST))  ? x + 1 : (d == int'(WEST))  ? x - 1 : x;
        localparam int  NY   = (d == int'(SOUTH)) ? y + 1 : (d == int'(NORTH)) ? y - 1 : y;
        localparam bit  EDGE = (NX < 0) || (NX >= X_SIZE) || (NY < 0) || (NY >= Y_SIZE);
        localparam int  EP   = (d == int'(NORTH)) ? x :
                               (d == int'(SOUTH)) ? X_SIZE + x :
                               (d == int'(WEST))  ? 2*X_SIZE + y : 2*X_SIZE + Y_SIZE + y;
        localparam int  OD   = d ^ 1;

        if (EDGE) begin : g_edge
          assign rid[R][d]                  = bus.i_dat[FLIT_W*EP +: FLIT_W];
          assign riv[R][d]                  = bus.i_valid[EP];
          assign bus.i_ready[EP]            = rir[R][d];
          assign bus.e_dat[FLIT_W*EP +: FLIT_W] = rod[R][d];
          assign bus.e_valid[EP]            = rov[R][d];
          assign ror[R][d]                  = bus.e_ready[EP];
        end else begin : g_link
          localparam int NB = NY * X_SIZE + NX;
          assign rid[R][d]   = rod[NB][OD];
          assign riv[R][d]   = rov[NB][OD];
          assign ror[NB][OD] = rir[R][d];
        end
      end
    end
  end
endmodule

// File: tb/tb_fwnoc_mesh.sv
module tb_fwnoc_mesh;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fwnoc_mesh_if #(.N_PORTS(8)) bus ();

  fwnoc_mesh #(.FIFO_DEPTH(4), .X_SIZE(2), .Y_SIZE(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          src;
    logic [31:0] hdr;
    logic [31:0] p0;
    logic [31:0] p1;
    int          dst;
    int          lat;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] dat;
    int          cyc;
  } eg_t;

  eg_t  egq[$];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (mon_en)
      for (int p = 0; p < 8; p++)
        if (bus.e_valid[p] && bus.e_ready[p])
          egq.push_back('{p, bus.e_dat[p*32 +: 32], cyc});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic sync();
    @(posedge clock); #1;
  endtask

  // Present one flit, hold it until accepted; acc = cycle of acceptance.
  task automatic send_flit(input int p, input logic [31:0] d, output int acc);
    int t;
    t = 0;
    bus.i_dat[p*32 +: 32] = d;
    bus.i_valid[p] = 1'b1;
    @(negedge clock);
    while (!bus.i_ready[p] && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) begin
      n_chk++;
      $display("FAIL accept port %0d: i_ready stuck low, required high", p);
    end
    acc = cyc;
    sync();
    bus.i_valid[p] = 1'b0;
  endtask

  task automatic wait_eg(input int n);
    int t;
    t = 0;
    while (egq.size() < n && t < 200) begin @(negedge clock); t++; end
    repeat (5) @(negedge clock);
    sync();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (3) sync();
    reset = 1'b1;
    sync();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] fl [3];
    int          acc [3];
    int          n;
    fl[0] = v.hdr; fl[1] = v.p0; fl[2] = v.p1;
    n = 1 + int'(v.hdr[15:8]);
    egq.delete();
    for (int k = 0; k < n; k++) send_flit(v.src, fl[k], acc[k]);
    wait_eg(n);
    check($sformatf("v%0d count", id), egq.size(), n);
    for (int k = 0; k < n; k++)
      if (k < egq.size()) begin
        check($sformatf("v%0d f%0d port", id, k), egq[k].port, v.dst);
        check($sformatf("v%0d f%0d data", id, k), egq[k].dat, fl[k]);
        check($sformatf("v%0d f%0d latency", id, k), 32'(egq[k].cyc - acc[k]), v.lat);
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [6];
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [31:0] bp [10];
    int          a, t, n_acc, stall;

    vt[0] = '{4, 32'h0000_0206, 32'h0000_00A1, 32'h0000_00A2, 6, 2};
    vt[1] = '{0, 32'h0000_0003, 32'h0,         32'h0,         3, 3};
    vt[2] = '{7, 32'h1234_0101, 32'h0000_BEEF, 32'h0,         1, 2};
    vt[3] = '{2, 32'h0000_0105, 32'h0000_C0DE, 32'h0,         5, 1};
    vt[4] = '{6, 32'h00AB_0004, 32'h0,         32'h0,         4, 2};
    vt[5] = '{3, 32'h5A5A_0200, 32'h0000_0011, 32'h0000_0022, 0, 3};

    bus.i_dat = '0; bus.i_valid = '0; bus.e_ready = '1;

    // reset behaviour
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("reset e_valid", 32'(bus.e_valid), 32'h0);
    check("reset i_ready", 32'(bus.i_ready), 32'h0);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("release i_ready", 32'(bus.i_ready), 32'hFF);
    mon_en = 1'b1;
    sync();

    for (int v = 0; v < 6; v++) run_vec(vt[v], v);

    // reset mid-packet: partial packet must vanish
    egq.delete();
    bus.e_ready = '0;
    send_flit(4, 32'h0000_0306, a);
    send_flit(4, 32'h0000_DEAD, a);
    repeat (3) sync();
    pulse_reset();
    bus.e_ready = '1;
    repeat (12) sync();
    check("mid-packet reset flush", egq.size(), 0);

    // contention: ports 0 and 4 both to port 7, N input wins first after reset
    egq.delete();
    ca[0] = 32'h0000_0307; ca[1] = 32'hB1; ca[2] = 32'hB2; ca[3] = 32'hB3;
    cb[0] = 32'h4444_0307; cb[1] = 32'hC1; cb[2] = 32'hC2; cb[3] = 32'hC3;
    for (int k = 0; k < 4; k++) begin
      bus.i_dat[0 +: 32] = ca[k];
      bus.i_dat[128 +: 32] = cb[k];
      bus.i_valid[0] = 1'b1; bus.i_valid[4] = 1'b1;
      t = 0;
      @(negedge clock);
      while (!(bus.i_ready[0] && bus.i_ready[4]) && t < 100) begin @(negedge clock); t++; end
      if (t >= 100) begin n_chk++; $display("FAIL contention accept: stuck, required accept"); end
      sync();
    end
    bus.i_valid[0] = 1'b0; bus.i_valid[4] = 1'b0;
    wait_eg(8);
    check("contention count", egq.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < egq.size()) begin
        check($sformatf("contention f%0d port", k), egq[k].port, 7);
        check($sformatf("contention f%0d data", k), egq[k].dat, (k < 4) ? ca[k] : cb[k-4]);
      end

    // back-pressure: port 6 blocked, port 4 streams a 10-flit packet
    egq.delete();
    bus.e_ready[6] = 1'b0;
    bp[0] = 32'h0000_0906;
    for (int k = 1; k < 10; k++) bp[k] = 32'h100 + k;
    n_acc = 0; stall = 0;
    while (n_acc < 10 && stall < 6) begin
      bus.i_dat[128 +: 32] = bp[n_acc];
      bus.i_valid[4] = 1'b1;
      @(negedge clock);
      if (bus.i_ready[4]) begin n_acc++; stall = 0; end
      else stall++;
      sync();
    end
    check("bp accepted before stall", n_acc, 8);
    @(negedge clock);
    check("bp i_ready low", 32'(bus.i_ready[4]), 32'h0);
    sync();
    // unrelated traffic 1 -> 2 still flows
    bus.i_valid[4] = 1'b0;
    send_flit(1, 32'h0000_0002, a);
    wait_eg(1);
    check("bp bypass count", egq.size(), 1);
    if (egq.size() > 0) check("bp bypass port", egq[0].port, 2);
    egq.delete();
    bus.e_ready[6] = 1'b1;
    for (int k = n_acc; k < 10; k++) send_flit(4, bp[k], a);
    wait_eg(10);
    check("bp delivered count", egq.size(), 10);
    for (int k = 0; k < 10; k++)
      if (k < egq.size()) begin
        check($sformatf("bp f%0d port", k), egq[k].port, 6);
        check($sformatf("bp f%0d data", k), egq[k].dat, bp[k]);
      end

    // invalid destination swallowed, then normal packet on same port
    egq.delete();
    send_flit(5, 32'h0000_0120, a);
    send_flit(5, 32'h0000_0077, a);
    repeat (10) sync();
    check("bad dest no egress", egq.size(), 0);
    send_flit(5, 32'h0000_0004, a);
    wait_eg(1);
    check("after bad count", egq.size(), 1);
    if (egq.size() > 0) begin
      check("after bad port", egq[0].port, 4);
      check("after bad data", egq[0].dat, 32'h0000_0004);
      check("after bad latency", 32'(egq[0].cyc - a), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
